// File: rtl/pa_cp0_info_pkg.sv
// Shared cp0 info-CSR definitions: CSR addresses, mcpuid index limits, FSM
// and requester encodings, plus the address decode helper.
// Latency: n/a (package). Backpressure: n/a.
// Optional feature macro used by the block: PA_CP0_INFO_DBG_EN.
package pa_cp0_info_pkg;

  // Last mcpuid index before the walk wraps to 0, and counter width.
  localparam int CPUID_IDX_MAX = 2;
  localparam int IDX_W         = 2;

  // Machine information CSR addresses.
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCPUID    = 12'hFC0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } info_state_e;

  typedef enum logic {
    REQ_IU  = 1'b0,
    REQ_DBG = 1'b1
  } info_req_e;

  // Result of decoding one read: data word, address error, and whether the
  // access hit mcpuid (which advances the requester's index).
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        is_cpuid;
  } info_rd_t;

  function automatic info_rd_t info_decode(
    input logic [11:0]      addr,
    input logic [31:0]      mvendorid,
    input logic [31:0]      marchid,
    input logic [31:0]      mimpid,
    input logic [31:0]      mhartid,
    input logic [95:0]      cpuid_words,
    input logic [IDX_W-1:0] idx
  );
    info_rd_t rd;
    rd = '0;
    case (addr)
      CSR_MVENDORID: rd.rdata = mvendorid;
      CSR_MARCHID:   rd.rdata = marchid;
      CSR_MIMPID:    rd.rdata = mimpid;
      CSR_MHARTID:   rd.rdata = mhartid;
      CSR_MCPUID: begin
        rd.is_cpuid = 1'b1;
        // Index 3 is never reached by the walk; if it appears, return 0.
        case (idx)
          2'd0:    rd.rdata = cpuid_words[31:0];
          2'd1:    rd.rdata = cpuid_words[63:32];
          2'd2:    rd.rdata = cpuid_words[95:64];
          default: rd.rdata = 32'h0;
        endcase
      end
      default: rd.err = 1'b1;
    endcase
    return rd;
  endfunction

endpackage

// File: rtl/pa_cp0_info_idx_cnt.sv
// One mcpuid index counter: walks 0..CPUID_IDX_MAX then wraps to 0.
// Latency: new index visible the cycle after i_inc/i_clr. Backpressure: none.
// Ports: i_clk, i_rst_b (async active-low), i_inc, i_clr (wins over inc), o_idx.
module pa_cp0_info_idx_cnt
  import pa_cp0_info_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_b,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;

  always_comb begin
    w_idx_nxt = r_idx;
    if (i_clr) begin
      w_idx_nxt = '0;
    end else if (i_inc) begin
      // ">=" also folds the unreachable value 3 back to 0.
      w_idx_nxt = (r_idx >= IDX_W'(CPUID_IDX_MAX)) ? '0 : r_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_idx <= '0;
    end else begin
      r_idx <= w_idx_nxt;
    end
  end

  assign o_idx = r_idx;

endmodule

// File: rtl/pa_cp0_info_rd_arb.sv
// Arbitrates info-CSR reads (mvendorid/marchid/mimpid/mhartid/mcpuid) between IU and debug.
// Latency: gnt combinational in IDLE, vld one cycle after gnt; one read per two cycles.
// Backpressure: req is held until gnt; no gnt while a response is being presented.
// Ports: regs_clk, cpurst_b; iu_info_* and dbg_info_* req/addr/gnt/vld/rdata/err;
//        info_idx_clr; info value inputs; cpuid_idx_value {idx2,idx1,idx0}; info_iu_idx.
// PA_CP0_INFO_DBG_EN: when undefined, debug outputs tie to 0 and no debug index exists.
module pa_cp0_info_rd_arb
  import pa_cp0_info_pkg::*;
(
  input  logic             regs_clk,
  input  logic             cpurst_b,
  input  logic             iu_info_req,
  input  logic [11:0]      iu_info_addr,
  output logic             iu_info_gnt,
  output logic             iu_info_vld,
  output logic [31:0]      iu_info_rdata,
  output logic             iu_info_err,
  input  logic             dbg_info_req,
  input  logic [11:0]      dbg_info_addr,
  output logic             dbg_info_gnt,
  output logic             dbg_info_vld,
  output logic [31:0]      dbg_info_rdata,
  output logic             dbg_info_err,
  input  logic             info_idx_clr,
  input  logic [31:0]      mvendorid_value,
  input  logic [31:0]      marchid_value,
  input  logic [31:0]      mimpid_value,
  input  logic [31:0]      mhartid_value,
  input  logic [95:0]      cpuid_idx_value,
  output logic [IDX_W-1:0] info_iu_idx
);

  info_state_e      r_state;
  info_state_e      w_state_nxt;
  logic             r_prio_dbg;   // 1: debug wins the next tie
  info_req_e        r_resp_owner; // requester whose response is in flight
  logic [31:0]      r_iu_rdata;
  logic             r_iu_err;

  logic             w_dbg_req;
  logic [11:0]      w_dbg_addr;
  logic [IDX_W-1:0] w_iu_idx;
  logic [IDX_W-1:0] w_dbg_idx;
  logic             w_iu_gnt;
  logic             w_dbg_gnt;
  logic             w_iu_vld;
  logic             w_dbg_vld;
  logic [11:0]      w_sel_addr;
  logic [IDX_W-1:0] w_sel_idx;
  info_rd_t         w_rd;
  logic             w_iu_inc;

`ifdef PA_CP0_INFO_DBG_EN
  assign w_dbg_req  = dbg_info_req;
  assign w_dbg_addr = dbg_info_addr;
`else
  assign w_dbg_req  = 1'b0;
  assign w_dbg_addr = 12'h000;
  // Debug inputs are intentionally ignored in this build.
  logic w_unused_dbg;
  assign w_unused_dbg = ^{dbg_info_req, dbg_info_addr};
`endif

  // FSM next state plus grant/valid decode.
  always_comb begin
    w_state_nxt = r_state;
    w_iu_gnt    = 1'b0;
    w_dbg_gnt   = 1'b0;
    w_iu_vld    = 1'b0;
    w_dbg_vld   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_iu_gnt  = iu_info_req & (~w_dbg_req | ~r_prio_dbg);
        w_dbg_gnt = w_dbg_req & (~iu_info_req | r_prio_dbg);
        if (w_iu_gnt || w_dbg_gnt) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_iu_vld    = (r_resp_owner == REQ_IU);
        w_dbg_vld   = (r_resp_owner == REQ_DBG);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Decode is shared: only the winner's address and index feed it.
  assign w_sel_addr = w_dbg_gnt ? w_dbg_addr : iu_info_addr;
  assign w_sel_idx  = w_dbg_gnt ? w_dbg_idx  : w_iu_idx;
  assign w_rd       = info_decode(w_sel_addr, mvendorid_value, marchid_value,
                                  mimpid_value, mhartid_value, cpuid_idx_value,
                                  w_sel_idx);
  assign w_iu_inc   = w_iu_gnt & w_rd.is_cpuid;

  always_ff @(posedge regs_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state      <= ST_IDLE;
      r_prio_dbg   <= 1'b0;
      r_resp_owner <= REQ_IU;
    end else begin
      r_state <= w_state_nxt;
      if (w_iu_gnt) begin
        r_prio_dbg   <= 1'b1;
        r_resp_owner <= REQ_IU;
      end else if (w_dbg_gnt) begin
        r_prio_dbg   <= 1'b0;
        r_resp_owner <= REQ_DBG;
      end
    end
  end

  // Per-port data/err registers hold until that port's next grant.
  always_ff @(posedge regs_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_iu_rdata <= 32'h0;
      r_iu_err   <= 1'b0;
    end else if (w_iu_gnt) begin
      r_iu_rdata <= w_rd.rdata;
      r_iu_err   <= w_rd.err;
    end
  end

  pa_cp0_info_idx_cnt u_iu_idx (
    .i_clk   (regs_clk),
    .i_rst_b (cpurst_b),
    .i_inc   (w_iu_inc),
    .i_clr   (info_idx_clr),
    .o_idx   (w_iu_idx)
  );

`ifdef PA_CP0_INFO_DBG_EN
  logic [31:0] r_dbg_rdata;
  logic        r_dbg_err;
  logic        w_dbg_inc;

  assign w_dbg_inc = w_dbg_gnt & w_rd.is_cpuid;

  always_ff @(posedge regs_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_dbg_rdata <= 32'h0;
      r_dbg_err   <= 1'b0;
    end else if (w_dbg_gnt) begin
      r_dbg_rdata <= w_rd.rdata;
      r_dbg_err   <= w_rd.err;
    end
  end

  pa_cp0_info_idx_cnt u_dbg_idx (
    .i_clk   (regs_clk),
    .i_rst_b (cpurst_b),
    .i_inc   (w_dbg_inc),
    .i_clr   (info_idx_clr),
    .o_idx   (w_dbg_idx)
  );

  assign dbg_info_gnt   = w_dbg_gnt;
  assign dbg_info_vld   = w_dbg_vld;
  assign dbg_info_rdata = r_dbg_rdata;
  assign dbg_info_err   = r_dbg_err;
`else
  assign w_dbg_idx      = '0;
  assign dbg_info_gnt   = 1'b0;
  assign dbg_info_vld   = 1'b0;
  assign dbg_info_rdata = 32'h0;
  assign dbg_info_err   = 1'b0;
  logic w_unused_dbg_vld;
  assign w_unused_dbg_vld = w_dbg_vld;
`endif

  assign iu_info_gnt   = w_iu_gnt;
  assign iu_info_vld   = w_iu_vld;
  assign iu_info_rdata = r_iu_rdata;
  assign iu_info_err   = r_iu_err;
  assign info_iu_idx   = w_iu_idx;

endmodule
